seq_mult_core: RTL and testbench

Sequential shift-add multiplier core that consumes the output of the 4-bit 2:1 operand mux. Each iteration it drives the mux select from the multiplier LSB and accumulates the selected addend, which is either zero on input A or the multiplicand on input B. It computes an unsigned WIDTH x WIDTH product over WIDTH iteration cycles, using a start/done handshake.

---
 rtl/seq_mult_core.sv | 116 +++++++++++
 tb/tb_seq_mult_core.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/seq_mult_core.sv
// seq_mult_core: unsigned shift-add multiplier, WIDTH x WIDTH -> 2*WIDTH bits.
// It runs one iteration per clock for WIDTH clocks. Each iteration steers an
// external 2:1 operand mux: input A is zero, input B is the latched
// multiplicand. The multiplier LSB picks the addend that goes into the
// accumulator.
//
// Handshake: start is sampled only in IDLE. After an accepted start, busy
// stays high through the done cycle. done is a single-cycle pulse, and product
// is valid in that cycle. product then holds until the final iteration of the
// next accepted operation.
module seq_mult_core #(
    parameter int WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WIDTH-1:0]     op_a,
    input  logic [WIDTH-1:0]     op_b,
    output logic [WIDTH-1:0]     mcand,
    output logic                 mux_sel,
    input  logic [WIDTH-1:0]     addend,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product,
    output logic [1:0]           dbg_state
);

    // The counter has one spare bit, so a power-of-two WIDTH never wraps early.
    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t               state_q;
    logic [WIDTH-1:0]     mcand_q;
    logic [2*WIDTH-1:0]   p_q;          // {accumulator, remaining multiplier}
    logic [CW-1:0]        cnt_q;
    logic [2*WIDTH-1:0]   product_q;
    logic                 busy_q;
    logic                 done_q;

    logic [WIDTH:0]       sum_d;        // accumulator + addend, carry kept
    logic [2*WIDTH-1:0]   p_d;          // P after one shift-add iteration
    logic                 last_iter_d;

    // One shift-add step. The carry becomes the accumulator MSB after the
    // right shift, so nothing is lost: 15*15 still fits in 8 bits.
    always_comb begin
        sum_d       = {1'b0, p_q[2*WIDTH-1:WIDTH]} + {1'b0, addend};
        p_d         = {sum_d, p_q[WIDTH-1:1]};
        last_iter_d = (cnt_q == CW'(WIDTH - 1));
    end

    // Control FSM and datapath registers. rst overrides any in-flight work,
    // so an aborted operation never produces a done pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            mcand_q   <= '0;
            p_q       <= '0;
            cnt_q     <= '0;
            product_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        mcand_q <= op_a;
                        p_q     <= {{WIDTH{1'b0}}, op_b};
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= CALC;
                    end
                end
                CALC: begin
                    p_q   <= p_d;
                    cnt_q <= cnt_q + CW'(1);
                    if (last_iter_d) begin
                        product_q <= p_d;
                        done_q    <= 1'b1;
                        state_q   <= DONE;
                    end
                end
                DONE: begin
                    // Any start seen here is dropped; the next request is
                    // sampled from IDLE.
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Outputs come straight from registers. mux_sel follows P[0] in every
    // state; the mux value only matters during CALC.
    always_comb begin
        mcand     = mcand_q;
        mux_sel   = p_q[0];
        busy      = busy_q;
        done      = done_q;
        product   = product_q;
        dbg_state = state_q;
    end

endmodule

// File: tb/tb_seq_mult_core.sv
// Directed bench for seq_mult_core (WIDTH=4). The bench models the external
// 2:1 operand mux: A is zero and B is mcand. Inputs are driven and outputs
// sampled on the falling edge.
module tb_seq_mult_core;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [3:0] op_a;
    logic [3:0] op_b;
    logic [3:0] mcand;
    logic       mux_sel;
    logic [3:0] addend;
    logic       busy;
    logic       done;
    logic [7:0] product;
    logic [1:0] dbg_state;

    int checks   = 0;
    int failures = 0;

    seq_mult_core #(.WIDTH(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .op_a      (op_a),
        .op_b      (op_b),
        .mcand     (mcand),
        .mux_sel   (mux_sel),
        .addend    (addend),
        .busy      (busy),
        .done      (done),
        .product   (product),
        .dbg_state (dbg_state)
    );

    // External operand mux: sel=0 -> 0, sel=1 -> multiplicand.
    assign addend = mux_sel ? mcand : 4'd0;

    // clock
    always #5 clk = ~clk;

    // Driver: called just after a falling edge with the DUT idle. It
    // presents a start for one cycle, then scrambles the operands. It records
    // the latency (1 = first cycle after the accept edge), the number of done
    // pulses, the mux_sel sequence over the four CALC cycles (LSB first),
    // busy during the operation and busy in the cycle after done. It returns
    // at the falling edge one cycle past done, with the DUT back in IDLE.
    task automatic do_mult(input logic [3:0] a, input logic [3:0] b,
                           output logic [7:0] prod, output int lat,
                           output int pulses, output logic [3:0] seq,
                           output logic busy_ok, output logic busy_after,
                           output logic [3:0] mc);
        lat = 0; pulses = 0; seq = '0; prod = 8'hxx;
        busy_ok = 1'b1; busy_after = 1'bx; mc = '0;
        start = 1'b1; op_a = a; op_b = b;
        @(negedge clk);
        start = 1'b0;
        op_a = 4'($urandom_range(0, 15));
        op_b = 4'($urandom_range(0, 15));
        mc = mcand;
        for (int cyc = 1; cyc <= 30; cyc++) begin
            if (cyc <= 4) seq[cyc-1] = mux_sel;
            if (lat == 0 && busy !== 1'b1) busy_ok = 1'b0;
            if (done === 1'b1) begin
                pulses++;
                if (lat == 0) begin
                    lat  = cyc;
                    prod = product;
                end
            end
            if (lat != 0 && cyc == lat + 1) begin
                busy_after = busy;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; op_a = 4'd0; op_b = 4'd0;
        repeat (3) @(negedge clk);
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
        checks++; if (product !== 8'd0) begin failures++; $display("FAIL reset_product got=%0d exp=0", product); end
        checks++; if (mux_sel !== 1'b0) begin failures++; $display("FAIL reset_mux_sel got=%b exp=0", mux_sel); end
        checks++; if (mcand !== 4'd0) begin failures++; $display("FAIL reset_mcand got=%0d exp=0", mcand); end
        checks++; if (dbg_state !== 2'd0) begin failures++; $display("FAIL reset_state got=%0d exp=0", dbg_state); end
        // start together with rst must be dropped
        start = 1'b1; op_a = 4'd5; op_b = 4'd5;
        @(negedge clk);
        rst = 1'b0; start = 1'b0;
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_start_busy got=%b exp=0", busy); end
        checks++; if (mcand !== 4'd0) begin failures++; $display("FAIL rst_start_mcand got=%0d exp=0", mcand); end
    endtask

    task automatic test_basic();
        logic [7:0] prod; int lat; int pulses; logic [3:0] seq;
        logic bok; logic bafter; logic [3:0] mc;
        do_mult(4'd5, 4'd3, prod, lat, pulses, seq, bok, bafter, mc);
        checks++; if (prod !== 8'd15) begin failures++; $display("FAIL mul_5x3 got=%0d exp=15", prod); end
        checks++; if (lat != 5) begin failures++; $display("FAIL lat_5x3 got=%0d exp=5", lat); end
        checks++; if (seq !== 4'b0011) begin failures++; $display("FAIL sel_5x3 got=%b exp=0011", seq); end
        checks++; if (pulses != 1) begin failures++; $display("FAIL pulses_5x3 got=%0d exp=1", pulses); end
        checks++; if (bok !== 1'b1) begin failures++; $display("FAIL busy_5x3 got=%b exp=1", bok); end
        checks++; if (bafter !== 1'b0) begin failures++; $display("FAIL busy_after_5x3 got=%b exp=0", bafter); end
        checks++; if (mc !== 4'd5) begin failures++; $display("FAIL mcand_5x3 got=%0d exp=5", mc); end

        do_mult(4'd15, 4'd15, prod, lat, pulses, seq, bok, bafter, mc);
        checks++; if (prod !== 8'hE1) begin failures++; $display("FAIL mul_15x15 got=%0d exp=225", prod); end
        checks++; if (seq !== 4'b1111) begin failures++; $display("FAIL sel_15x15 got=%b exp=1111", seq); end

        do_mult(4'd0, 4'd9, prod, lat, pulses, seq, bok, bafter, mc);
        checks++; if (prod !== 8'd0) begin failures++; $display("FAIL mul_0x9 got=%0d exp=0", prod); end
        checks++; if (seq !== 4'b1001) begin failures++; $display("FAIL sel_0x9 got=%b exp=1001", seq); end

        do_mult(4'd9, 4'd0, prod, lat, pulses, seq, bok, bafter, mc);
        checks++; if (prod !== 8'd0) begin failures++; $display("FAIL mul_9x0 got=%0d exp=0", prod); end
        checks++; if (seq !== 4'b0000) begin failures++; $display("FAIL sel_9x0 got=%b exp=0000", seq); end
    endtask

    task automatic test_exhaustive();
        logic [7:0] prod; int lat; int pulses; logic [3:0] seq;
        logic bok; logic bafter; logic [3:0] mc; logic [7:0] exp_p;
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                do_mult(4'(a), 4'(b), prod, lat, pulses, seq, bok, bafter, mc);
                exp_p = 8'(a * b);
                checks++; if (prod !== exp_p) begin failures++; $display("FAIL exh_product a=%0d b=%0d got=%0d exp=%0d", a, b, prod, exp_p); end
                checks++; if (pulses != 1) begin failures++; $display("FAIL exh_pulses a=%0d b=%0d got=%0d exp=1", a, b, pulses); end
                checks++; if (lat != 5) begin failures++; $display("FAIL exh_latency a=%0d b=%0d got=%0d exp=5", a, b, lat); end
            end
        end
    endtask

    // start held high: accepts land at t=0,6,12. Operands at t are
    // a=(t+3)%16 and b=(2t+1)%16, so the products are 3*1, 9*13 and 15*9.
    task automatic test_back_to_back();
        int done_t[3];
        logic [7:0] done_p[3];
        int n;
        n = 0;
        for (int t = 0; t <= 17; t++) begin
            if (t > 0 && done === 1'b1) begin
                if (n < 3) begin done_t[n] = t; done_p[n] = product; end
                n++;
            end
            if (t == 17) start = 1'b0;
            else begin
                start = 1'b1;
                op_a  = 4'((t + 3) % 16);
                op_b  = 4'((2 * t + 1) % 16);
            end
            @(negedge clk);
        end
        checks++; if (n != 3) begin failures++; $display("FAIL b2b_count got=%0d exp=3", n); end
        if (n >= 3) begin
            checks++; if (done_t[0] != 5 || done_t[1] != 11 || done_t[2] != 17) begin failures++; $display("FAIL b2b_timing got=%0d,%0d,%0d exp=5,11,17", done_t[0], done_t[1], done_t[2]); end
            checks++; if (done_p[0] !== 8'd3) begin failures++; $display("FAIL b2b_p0 got=%0d exp=3", done_p[0]); end
            checks++; if (done_p[1] !== 8'd117) begin failures++; $display("FAIL b2b_p1 got=%0d exp=117", done_p[1]); end
            checks++; if (done_p[2] !== 8'd135) begin failures++; $display("FAIL b2b_p2 got=%0d exp=135", done_p[2]); end
        end
        repeat (2) @(negedge clk);
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL b2b_idle got=%b exp=0", busy); end
    endtask

    task automatic test_abort();
        logic [7:0] prod; int lat; int pulses; logic [3:0] seq;
        logic bok; logic bafter; logic [3:0] mc; int seen;
        start = 1'b1; op_a = 4'd7; op_b = 4'd6;
        @(negedge clk);           // accepted; first CALC cycle
        start = 1'b0;
        @(negedge clk);           // second CALC cycle
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL abort_busy got=%b exp=0", busy); end
        checks++; if (product !== 8'd0) begin failures++; $display("FAIL abort_product got=%0d exp=0", product); end
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            if (done !== 1'b0) seen++;
            @(negedge clk);
        end
        checks++; if (seen != 0) begin failures++; $display("FAIL abort_done got=%0d exp=0", seen); end
        do_mult(4'd7, 4'd6, prod, lat, pulses, seq, bok, bafter, mc);
        checks++; if (prod !== 8'd42) begin failures++; $display("FAIL after_abort got=%0d exp=42", prod); end
    endtask

    task automatic test_hold();
        logic [7:0] prod; int lat; int pulses; logic [3:0] seq;
        logic bok; logic bafter; logic [3:0] mc;
        do_mult(4'd11, 4'd13, prod, lat, pulses, seq, bok, bafter, mc);
        checks++; if (prod !== 8'd143) begin failures++; $display("FAIL mul_11x13 got=%0d exp=143", prod); end
        for (int i = 0; i < 20; i++) begin
            op_a = 4'($urandom_range(0, 15));
            op_b = 4'($urandom_range(0, 15));
            @(negedge clk);
            checks++; if (product !== 8'd143) begin failures++; $display("FAIL hold_product cyc=%0d got=%0d exp=143", i, product); end
            checks++; if (done !== 1'b0) begin failures++; $display("FAIL hold_done cyc=%0d got=%b exp=0", i, done); end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_exhaustive();
        test_back_to_back();
        test_abort();
        test_hold();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
